// File: rtl/trace_pkg.sv
// Shared definitions for the instruction trace unit: FSM encodings and record layout.
package trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_READ  = 2'd3
    } state_t;

    // Field positions in units of DATA_WIDTH; pc occupies the top PC_WIDTH bits.
    localparam int FLAGS_LSB  = 0;
    localparam int THIRD_LSB  = 1;
    localparam int SECOND_LSB = 2;
    localparam int INSTR_LSB  = 3;
    localparam int PC_LSB     = 4;

    function automatic int field_lsb(input int slot, input int data_width);
        return slot * data_width;
    endfunction

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port record store: one write port, one registered read port.
module trace_ram #(
    parameter int DEPTH  = 64,
    parameter int WIDTH  = 48,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/trace_buffer.sv
// Instruction trace unit: circular capture of retired instructions, PC-match
// trigger with programmable post-trigger depth, oldest-first valid/ready readout.
module trace_buffer
    import trace_pkg::*;
#(
    parameter int PC_WIDTH   = 16,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 64,
    localparam int ADDR_W    = $clog2(DEPTH),
    localparam int REC_W     = PC_WIDTH + 4*DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  arm,
    input  logic                  trig_en,
    input  logic [PC_WIDTH-1:0]   trig_pc,
    input  logic                  force_trig,
    input  logic [ADDR_W:0]       post_count,
    input  logic                  retire,
    input  logic [PC_WIDTH-1:0]   ret_pc,
    input  logic [DATA_WIDTH-1:0] ret_instr,
    input  logic [DATA_WIDTH-1:0] ret_second,
    input  logic [DATA_WIDTH-1:0] ret_third,
    input  logic [DATA_WIDTH-1:0] ret_flags,
    output logic [1:0]            state,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [REC_W-1:0]      rd_data,
    output logic                  rd_last,
    output logic                  wrapped
);

    localparam logic [ADDR_W:0] FULL     = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] POST_MAX = (ADDR_W+1)'(DEPTH-1);

    state_t            st, st_n;
    logic [ADDR_W-1:0] wptr, raddr;
    logic [ADDR_W:0]   count, post_rem, post_clamp, rd_idx;
    logic              clear, wr_en, rd_en, trig, xfer;
    logic [REC_W-1:0]  wdata, q;

    assign state      = st;
    assign xfer       = rd_valid & rd_ready;
    assign trig       = force_trig | (trig_en & retire & (ret_pc == trig_pc));
    assign post_clamp = (post_count > POST_MAX) ? POST_MAX : post_count;
    // Oldest record sits count slots behind the write pointer; a full buffer wraps to wptr itself.
    assign raddr      = wptr - count[ADDR_W-1:0] + rd_idx[ADDR_W-1:0];
    assign rd_data    = rd_valid ? q : '0;

    always_comb begin
        wdata = '0;
        wdata[field_lsb(PC_LSB, DATA_WIDTH)     +: PC_WIDTH]   = ret_pc;
        wdata[field_lsb(INSTR_LSB, DATA_WIDTH)  +: DATA_WIDTH] = ret_instr;
        wdata[field_lsb(SECOND_LSB, DATA_WIDTH) +: DATA_WIDTH] = ret_second;
        wdata[field_lsb(THIRD_LSB, DATA_WIDTH)  +: DATA_WIDTH] = ret_third;
        wdata[field_lsb(FLAGS_LSB, DATA_WIDTH)  +: DATA_WIDTH] = ret_flags;
    end

    always_comb begin
        st_n  = st;
        clear = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        case (st)
            ST_IDLE: if (arm) begin
                st_n  = ST_ARMED;
                clear = 1'b1;
            end
            ST_ARMED: begin
                wr_en = retire;
                if (trig) st_n = (post_clamp == '0) ? ST_READ : ST_POST;
            end
            ST_POST: begin
                if (arm) begin
                    st_n  = ST_ARMED;
                    clear = 1'b1;
                end else if (retire) begin
                    wr_en = 1'b1;
                    if (post_rem == (ADDR_W+1)'(1)) st_n = ST_READ;
                end
            end
            default: begin
                if (arm) begin
                    st_n  = ST_ARMED;
                    clear = 1'b1;
                end else if (count == '0 || (xfer && rd_last)) begin
                    st_n = ST_IDLE;
                end else begin
                    rd_en = ~rd_valid;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            st       <= ST_IDLE;
            wptr     <= '0;
            count    <= '0;
            wrapped  <= 1'b0;
            post_rem <= '0;
            rd_idx   <= '0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
        end else begin
            st <= st_n;
            if (clear) begin
                wptr    <= '0;
                count   <= '0;
                wrapped <= 1'b0;
            end else if (wr_en) begin
                wptr <= wptr + 1'b1;
                if (count != FULL)      count   <= count + 1'b1;
                else if (st == ST_ARMED) wrapped <= 1'b1;
            end
            if (st == ST_ARMED && trig)    post_rem <= post_clamp;
            else if (st == ST_POST && wr_en) post_rem <= post_rem - 1'b1;

            if (st != ST_READ)  rd_idx <= '0;
            else if (xfer)      rd_idx <= rd_idx + 1'b1;

            // One idle cycle after each transfer gives the RAM time to fetch the next record.
            if (st != ST_READ || st_n != ST_READ) begin
                rd_valid <= 1'b0;
                rd_last  <= 1'b0;
            end else if (rd_en) begin
                rd_valid <= 1'b1;
                rd_last  <= (rd_idx + 1'b1 == count);
            end else if (xfer) begin
                rd_valid <= 1'b0;
                rd_last  <= 1'b0;
            end
        end
    end

    trace_ram #(.DEPTH(DEPTH), .WIDTH(REC_W)) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wptr),
        .wr_data (wdata),
        .rd_en   (rd_en),
        .rd_addr (raddr),
        .rd_data (q)
    );

endmodule

// File: tb/tb_trace_buffer.sv
// Directed-sequence bench with randomized record fields, checked against a queue model of the window.
module tb_trace_buffer;

    localparam int PW = 16, DW = 8, DEPTH = 64, AW = 6, RW = PW + 4*DW;

    logic          clk = 0, reset_n = 0, arm = 0, trig_en = 0, force_trig = 0, retire = 0, rd_ready = 0;
    logic [PW-1:0] trig_pc = '0, ret_pc = '0;
    logic [AW:0]   post_count = '0;
    logic [DW-1:0] ret_instr = '0, ret_second = '0, ret_third = '0, ret_flags = '0;
    logic [1:0]    state;
    logic          rd_valid, rd_last, wrapped;
    logic [RW-1:0] rd_data;

    int vectors = 0, errs = 0;
    logic [RW-1:0] hist[$];

    trace_buffer dut (
        .clk(clk), .reset_n(reset_n), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
        .force_trig(force_trig), .post_count(post_count), .retire(retire), .ret_pc(ret_pc),
        .ret_instr(ret_instr), .ret_second(ret_second), .ret_third(ret_third), .ret_flags(ret_flags),
        .state(state), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .rd_last(rd_last), .wrapped(wrapped)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Retire one instruction; when capture is expected, the model keeps the newest DEPTH records.
    task automatic do_retire(input logic [PW-1:0] pc, input bit capture);
        ret_pc     = pc;
        ret_instr  = DW'($urandom);
        ret_second = DW'($urandom);
        ret_third  = DW'($urandom);
        ret_flags  = DW'($urandom);
        retire     = 1;
        step();
        retire     = 0;
        if (capture) begin
            hist.push_back({pc, ret_instr, ret_second, ret_third, ret_flags});
            if (hist.size() > DEPTH) void'(hist.pop_front());
        end
    endtask

    task automatic do_arm();
        arm = 1;
        step();
        arm = 0;
        hist.delete();
        chk("arm_state", state, 1);
        chk("arm_wrapped", wrapped, 0);
    endtask

    // Called right after the edge that entered READ.
    task automatic read_window(input int abort_after, input int hold_idx);
        int n;
        n = hist.size();
        chk("entry_no_valid", rd_valid, 0);
        step();
        chk("first_valid", rd_valid, 1);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("rd_data[%0d]", i), rd_data, hist[i]);
            chk($sformatf("rd_last[%0d]", i), rd_last, (i == n-1));
            if (i == hold_idx) begin
                for (int k = 0; k < 10; k++) begin
                    step();
                    chk("hold_valid", rd_valid, 1);
                    chk("hold_data", rd_data, hist[i]);
                end
            end
            rd_ready = 1;
            step();
            rd_ready = 0;
            chk("gap_valid", rd_valid, 0);
            if (i == n-1) begin
                chk("end_state", state, 0);
            end else begin
                step();
                chk("next_valid", rd_valid, 1);
                if (abort_after == i+1) return;
            end
        end
    endtask

    initial begin
        step();
        step();
        chk("rst_state", state, 0);
        chk("rst_valid", rd_valid, 0);
        chk("rst_last", rd_last, 0);
        chk("rst_data", rd_data, 0);
        chk("rst_wrapped", wrapped, 0);
        reset_n = 1;
        step();

        // Basic window: trigger at 0x12 with two post records
        do_retire(16'h0008, 0);
        chk("idle_ignores_retire", state, 0);
        trig_en = 1; trig_pc = 16'h0012; post_count = 2;
        do_arm();
        do_retire(16'h000C, 1);
        do_retire(16'h000E, 1);
        do_retire(16'h0010, 1);
        chk("basic_armed", state, 1);
        do_retire(16'h0012, 1);
        chk("basic_post", state, 2);
        do_retire(16'h0014, 1);
        chk("basic_post2", state, 2);
        do_retire(16'h0016, 1);
        chk("basic_read", state, 3);
        chk("basic_wrapped", wrapped, 0);
        read_window(0, -1);

        // Wrap: 100 pre-trigger records, post 0 -> READ on the trigger record
        trig_pc = 16'd100; post_count = 0;
        do_arm();
        for (int p = 0; p < 100; p++) do_retire(PW'(p), 1);
        chk("wrap_armed", state, 1);
        do_retire(16'd100, 1);
        chk("wrap_read", state, 3);
        chk("wrap_wrapped", wrapped, 1);
        chk("wrap_first_pc", {16'h0, hist[0][RW-1 -: PW]}, 37);
        read_window(0, -1);

        // Clamp: post_count above DEPTH-1 gives exactly 63 post records; backpressure mid-readout
        trig_pc = 16'h0500; post_count = 7'd100;
        do_arm();
        for (int p = 0; p < 3; p++) do_retire(PW'($urandom_range(16'h1000, 16'h1FFF)), 1);
        do_retire(16'h0500, 1);
        chk("clamp_post", state, 2);
        for (int p = 0; p < 62; p++) do_retire(PW'($urandom_range(16'h2000, 16'h2FFF)), 1);
        chk("clamp_still_post", state, 2);
        do_retire(16'h0500, 1);
        chk("clamp_read", state, 3);
        read_window(0, 5);

        // force_trig with nothing captured: no valid, back to IDLE after one cycle
        post_count = 0;
        do_arm();
        force_trig = 1;
        step();
        force_trig = 0;
        chk("force_read", state, 3);
        chk("force_no_valid", rd_valid, 0);
        step();
        chk("force_idle", state, 0);
        chk("force_idle_valid", rd_valid, 0);

        // Abort readout with arm after 2 of 5 records
        trig_pc = 16'h0040; post_count = 1;
        do_arm();
        do_retire(16'h003A, 1);
        do_retire(16'h003C, 1);
        do_retire(16'h003E, 1);
        do_retire(16'h0040, 1);
        do_retire(16'h0042, 1);
        chk("abort_read", state, 3);
        read_window(2, -1);
        arm = 1;
        step();
        arm = 0;
        hist.delete();
        chk("abort_state", state, 1);
        chk("abort_valid", rd_valid, 0);

        // Reset during POST after a wrapping capture
        trig_pc = 16'h0800; post_count = 5;
        for (int p = 0; p < 70; p++) do_retire(PW'(16'h0100 + p), 1);
        chk("pre_rst_wrapped", wrapped, 1);
        do_retire(16'h0800, 1);
        do_retire(16'h0802, 1);
        chk("pre_rst_post", state, 2);
        reset_n = 0;
        step();
        reset_n = 1;
        hist.delete();
        chk("rst_post_state", state, 0);
        chk("rst_post_valid", rd_valid, 0);
        chk("rst_post_wrapped", wrapped, 0);
        do_retire(16'h0804, 0);
        do_retire(16'h0800, 0);
        chk("rst_no_capture", state, 0);
        post_count = 0;
        do_arm();
        do_retire(16'h0900, 1);
        do_retire(16'h0902, 1);
        force_trig = 1;
        step();
        force_trig = 0;
        chk("rst_force_read", state, 3);
        read_window(0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
